wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port fed by the writeback stage. It merges two requesters: the in-order pipeline writeback (port A, from the MEM latch, strict priority, no backpressure) and a long-latency functional unit (port B, valid/ready, buffered in a small FIFO). It emits one registered write per cycle toward the DE-stage register file. It also raises a registered pipeline stall when port B starves.

## Interface
Parameters:
- DBITS, 32, data width
- REGNOBITS, 5, register-number width
- B_DEPTH, 4, port-B FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive cycles a FIFO head may wait before a stall is forced (≥1)

Ports (the clock is `clk` and the reset is `reset`; `reset` is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- a_valid  in  1  pipeline writeback request
- a_wregno  in  REGNOBITS  pipeline destination register
- a_regval  in  DBITS  pipeline write data
- b_valid  in  1  long-latency unit result valid
- b_ready  out  1  FIFO can accept (= !full)
- b_wregno  in  REGNOBITS  unit destination register
- b_regval  in  DBITS  unit write data
- wr_en  out  1  register-file write enable (registered)
- wr_regno  out  REGNOBITS  write register number (registered)
- wr_data  out  DBITS  write data (registered)
- stall_out  out  1  pipeline must not present a_valid next cycle (registered)
- proto_err  out  1  sticky: a_valid seen while stall_out=1
- b_count  out  $clog2(B_DEPTH)+1  FIFO occupancy

## Operation
- Push: b_valid && b_ready writes {b_wregno, b_regval} at the FIFO tail. b_ready depends only on occupancy, so there is no same-cycle pass-through even when a pop occurs.
- Grant each cycle, in priority order:
  - If a_valid: grant A.
  - Else if the FIFO is non-empty: grant the FIFO head and pop it.
  - Else: no write.
- Registering: the granted request is captured into wr_en/wr_regno/wr_data at the next edge.
- Writes to register 0: granted and popped normally, but wr_en=0 for that slot.
- Starvation: starve_cnt increments in every cycle the FIFO is non-empty and the head is not popped. It clears on a pop or when the FIFO is empty.
- Stall:
  - stall_out is set when starve_cnt reaches STARVE_LIMIT.
  - stall_out clears at the edge where the head is popped.
  - With stall_out=1, the pipeline holds a_valid=0, so the head wins.
  - If a_valid=1 arrives anyway, A still wins (no write is dropped) and proto_err sets; it is sticky until reset.
- Push and pop in the same cycle: occupancy is unchanged.
- Push when full: impossible by protocol (b_ready=0); b_valid is ignored.
- Ordering hazards between A and B to the same register are not resolved here. The scoreboard upstream prevents them.

## Timing
- Port A: a_valid at cycle N → wr_en=1 at cycle N+1.
- Port B, empty FIFO, A idle: push at cycle N → head visible at N+1 → wr_en at N+2.
- Throughput: one write per cycle. Sustained A traffic starves B until stall_out fires.
- Worst-case B latency once at the head, with a well-behaved pipeline: STARVE_LIMIT+2 cycles.
- Reset (asynchronous, any time, including mid-drain):
  - FIFO emptied, pointers and starve_cnt cleared.
  - wr_en=0, wr_regno=0, wr_data=0.
  - stall_out=0, proto_err=0, b_count=0.
  - b_ready=1 in the first cycle after reset deasserts.

## Configuration
- WB_ARB_HAZARD_EN:
  - Defined: adds input q_regno [REGNOBITS] and output q_pending [1].
  - q_pending is combinational and is 1 iff some valid FIFO entry has wregno == q_regno and q_regno ≠ 0. It is used by DE to stall readers of in-flight unit results.
  - Undefined: these ports and the comparison logic are absent.

## Test plan
- A only: a_valid with (r3, 0x1234) at cycle 5 → wr_en=1, wr_regno=3, wr_data=0x1234 at cycle 6; no B activity; stall_out=0.
- B only: push (r7, 0xCAFE) at cycle 10 with A idle → write at cycle 12; b_count goes 0→1→0.
- Fill and backpressure: push B_DEPTH=4 entries while a_valid=1 continuously → b_ready=0 after the 4th push.
- Starvation: with the fill above and A still asserted → stall_out=1 after 8 cycles. Drop a_valid the next cycle → the head is written and stall_out clears. Entries drain in FIFO order; proto_err stays 0.
- Protocol error and x0: assert a_valid while stall_out=1 → A is written and proto_err=1 (sticky). Push B to r0 → popped, with no wr_en pulse.
- Reset mid-operation: with 3 entries queued and stall_out=1, pulse reset → all outputs 0 immediately; b_ready=1 after release. With WB_ARB_HAZARD_EN, q_pending=0 for every q_regno.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: pipeline writeback (A, strict priority) merged with a FIFO-buffered
// long-latency unit (B), with starvation stall. Optional in-flight query: `define WB_ARB_HAZARD_EN.
module wb_port_arbiter #(
  parameter int DBITS        = 32,
  parameter int REGNOBITS    = 5,
  parameter int B_DEPTH      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_valid,
  input  logic [REGNOBITS-1:0]      a_wregno,
  input  logic [DBITS-1:0]          a_regval,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [REGNOBITS-1:0]      b_wregno,
  input  logic [DBITS-1:0]          b_regval,
  output logic                      wr_en,
  output logic [REGNOBITS-1:0]      wr_regno,
  output logic [DBITS-1:0]          wr_data,
  output logic                      stall_out,
  output logic                      proto_err,
`ifdef WB_ARB_HAZARD_EN
  input  logic [REGNOBITS-1:0]      q_regno,
  output logic                      q_pending,
`endif
  output logic [$clog2(B_DEPTH):0]  b_count
);

  localparam int PTRW = $clog2(B_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  logic [REGNOBITS-1:0] mem_regno [B_DEPTH];
  logic [DBITS-1:0]     mem_data  [B_DEPTH];

  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 stall_q, stall_d;
  logic                 proto_q, proto_d;
  logic                 wr_en_q, wr_en_d;
  logic [REGNOBITS-1:0] wr_regno_q, wr_regno_d;
  logic [DBITS-1:0]     wr_data_q, wr_data_d;

  logic                 empty, full, push, pop;
  logic [REGNOBITS-1:0] head_regno;
  logic [DBITS-1:0]     head_data;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNTW'(B_DEPTH));
  assign push       = b_valid && !full;
  assign pop        = !a_valid && !empty;
  assign head_regno = mem_regno[rd_ptr_q];
  assign head_data  = mem_data[rd_ptr_q];

  // Storage carries no reset; validity is defined solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_regno[wr_ptr_q] <= b_wregno;
      mem_data[wr_ptr_q]  <= b_regval;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    stall_d    = stall_q;
    proto_d    = proto_q | (a_valid & stall_q);
    wr_en_d    = 1'b0;
    wr_regno_d = '0;
    wr_data_d  = '0;

    if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);

    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);

    if (empty || pop)                         starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))   starve_d = starve_q + SW'(1);

    // The stall is asserted one edge after the limit is observed, giving the pipeline a
    // full cycle to see it before the head is forced through.
    if (pop)                                  stall_d = 1'b0;
    else if (starve_q == SW'(STARVE_LIMIT))   stall_d = 1'b1;

    if (a_valid) begin
      wr_en_d    = (a_wregno != '0);
      wr_regno_d = a_wregno;
      wr_data_d  = a_regval;
    end else if (!empty) begin
      wr_en_d    = (head_regno != '0);
      wr_regno_d = head_regno;
      wr_data_d  = head_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      proto_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_regno_q <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      proto_q    <= proto_d;
      wr_en_q    <= wr_en_d;
      wr_regno_q <= wr_regno_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign b_ready   = !full;
  assign b_count   = count_q;
  assign wr_en     = wr_en_q;
  assign wr_regno  = wr_regno_q;
  assign wr_data   = wr_data_q;
  assign stall_out = stall_q;
  assign proto_err = proto_q;

`ifdef WB_ARB_HAZARD_EN
  logic [PTRW-1:0] slot;

  // Walk the occupied slots starting at the head; x0 never creates a hazard.
  always_comb begin
    q_pending = 1'b0;
    slot      = '0;
    for (int k = 0; k < B_DEPTH; k++) begin
      slot = rd_ptr_q + PTRW'(k);
      if ((CNTW'(k) < count_q) && (mem_regno[slot] == q_regno) && (q_regno != '0))
        q_pending = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, port A, port B, fill/backpressure, starvation
// stall, protocol error, x0 suppression and asynchronous reset mid-operation.
module tb_wb_port_arbiter;
  localparam int DBITS        = 32;
  localparam int REGNOBITS    = 5;
  localparam int B_DEPTH      = 4;
  localparam int STARVE_LIMIT = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    a_valid;
  logic [REGNOBITS-1:0]    a_wregno;
  logic [DBITS-1:0]        a_regval;
  logic                    b_valid;
  logic                    b_ready;
  logic [REGNOBITS-1:0]    b_wregno;
  logic [DBITS-1:0]        b_regval;
  logic                    wr_en;
  logic [REGNOBITS-1:0]    wr_regno;
  logic [DBITS-1:0]        wr_data;
  logic                    stall_out;
  logic                    proto_err;
  logic [$clog2(B_DEPTH):0] b_count;
`ifdef WB_ARB_HAZARD_EN
  logic [REGNOBITS-1:0]    q_regno;
  logic                    q_pending;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(
    .DBITS(DBITS), .REGNOBITS(REGNOBITS), .B_DEPTH(B_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_wregno(a_wregno), .a_regval(a_regval),
    .b_valid(b_valid), .b_ready(b_ready), .b_wregno(b_wregno), .b_regval(b_regval),
    .wr_en(wr_en), .wr_regno(wr_regno), .wr_data(wr_data),
    .stall_out(stall_out), .proto_err(proto_err),
`ifdef WB_ARB_HAZARD_EN
    .q_regno(q_regno), .q_pending(q_pending),
`endif
    .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_wregno = '0; a_regval = '0;
    b_valid = 1'b0; b_wregno = '0; b_regval = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %0b exp 0", wr_en); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b exp 0", stall_out); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto: got %0b exp 0", proto_err); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL rst_b_count: got %0d exp 0", b_count); end
    reset = 1'b0;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready: got %0b exp 1", b_ready); end
    step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_idle_wr_en: got %0b exp 0", wr_en); end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_wregno = 5'd3; a_regval = 32'h1234;
    step();
    a_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL a_wr_en: got %0b exp 1", wr_en); end
    n_checks++; if (wr_regno !== 5'd3) begin n_fail++; $display("FAIL a_wr_regno: got %0d exp 3", wr_regno); end
    n_checks++; if (wr_data !== 32'h1234) begin n_fail++; $display("FAIL a_wr_data: got %h exp 1234", wr_data); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL a_stall: got %0b exp 0", stall_out); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL a_b_count: got %0d exp 0", b_count); end
    step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL a_after_wr_en: got %0b exp 0", wr_en); end
  endtask

  task automatic test_b_only();
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_ready_empty: got %0b exp 1", b_ready); end
    b_valid = 1'b1; b_wregno = 5'd7; b_regval = 32'hCAFE;
    step();
    b_valid = 1'b0;
    n_checks++; if (b_count !== 3'd1) begin n_fail++; $display("FAIL b_count_push: got %0d exp 1", b_count); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b_early_wr_en: got %0b exp 0", wr_en); end
    step();
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL b_wr_en: got %0b exp 1", wr_en); end
    n_checks++; if (wr_regno !== 5'd7) begin n_fail++; $display("FAIL b_wr_regno: got %0d exp 7", wr_regno); end
    n_checks++; if (wr_data !== 32'hCAFE) begin n_fail++; $display("FAIL b_wr_data: got %h exp cafe", wr_data); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL b_count_pop: got %0d exp 0", b_count); end
    step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b_after_wr_en: got %0b exp 0", wr_en); end
  endtask

  task automatic test_fill_starve();
    a_valid = 1'b1; a_wregno = 5'd1; a_regval = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_wregno = 5'(10 + i); b_regval = 32'hB0 + 32'(i);
      step();
    end
    // Offer a fifth entry while full; it must be ignored.
    b_wregno = 5'd20; b_regval = 32'hDEAD;
    n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("FAIL fill_b_count: got %0d exp 4", b_count); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL fill_b_ready: got %0b exp 0", b_ready); end
    n_checks++; if (wr_regno !== 5'd1) begin n_fail++; $display("FAIL fill_a_regno: got %0d exp 1", wr_regno); end
    for (int c = 5; c <= 10; c++) begin
      step();
      b_valid = 1'b0;
      n_checks++;
      if (stall_out !== (c == 10)) begin
        n_fail++; $display("FAIL starve_stall_c%0d: got %0b exp %0b", c, stall_out, (c == 10));
      end
    end
    n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("FAIL full_ignore_count: got %0d exp 4", b_count); end
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL drain_wr_en_%0d: got %0b exp 1", i, wr_en); end
      n_checks++; if (wr_regno !== 5'(10 + i)) begin n_fail++; $display("FAIL drain_regno_%0d: got %0d exp %0d", i, wr_regno, 10 + i); end
      n_checks++; if (wr_data !== 32'hB0 + 32'(i)) begin n_fail++; $display("FAIL drain_data_%0d: got %h exp %h", i, wr_data, 32'hB0 + 32'(i)); end
      n_checks++; if (b_count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count_%0d: got %0d exp %0d", i, b_count, 3 - i); end
      n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL drain_stall_%0d: got %0b exp 0", i, stall_out); end
    end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL drain_proto: got %0b exp 0", proto_err); end
    step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL drain_idle_wr_en: got %0b exp 0", wr_en); end
  endtask

  task automatic test_proto_x0();
    a_valid = 1'b1; a_wregno = 5'd2; a_regval = 32'h22;
    b_valid = 1'b1; b_wregno = 5'd5; b_regval = 32'h55;
    step();
    b_valid = 1'b0;
    for (int c = 2; c <= 10; c++) step();
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL pe_stall_set: got %0b exp 1", stall_out); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL pe_before: got %0b exp 0", proto_err); end
    a_wregno = 5'd4; a_regval = 32'h44;
    step();
    a_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL pe_a_wr_en: got %0b exp 1", wr_en); end
    n_checks++; if (wr_regno !== 5'd4) begin n_fail++; $display("FAIL pe_a_regno: got %0d exp 4", wr_regno); end
    n_checks++; if (wr_data !== 32'h44) begin n_fail++; $display("FAIL pe_a_data: got %h exp 44", wr_data); end
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_set: got %0b exp 1", proto_err); end
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL pe_stall_hold: got %0b exp 1", stall_out); end
    n_checks++; if (b_count !== 3'd1) begin n_fail++; $display("FAIL pe_count: got %0d exp 1", b_count); end
    step();
    n_checks++; if (wr_regno !== 5'd5) begin n_fail++; $display("FAIL pe_head_regno: got %0d exp 5", wr_regno); end
    n_checks++; if (wr_data !== 32'h55) begin n_fail++; $display("FAIL pe_head_data: got %h exp 55", wr_data); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL pe_stall_clr: got %0b exp 0", stall_out); end
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_sticky: got %0b exp 1", proto_err); end
    b_valid = 1'b1; b_wregno = 5'd0; b_regval = 32'h99;
    step();
    b_valid = 1'b0;
    n_checks++; if (b_count !== 3'd1) begin n_fail++; $display("FAIL x0_count_push: got %0d exp 1", b_count); end
    step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %0b exp 0", wr_en); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL x0_popped: got %0d exp 0", b_count); end
  endtask

`ifdef WB_ARB_HAZARD_EN
  task automatic test_hazard();
    a_valid = 1'b1; a_wregno = 5'd1; a_regval = 32'h11;
    b_valid = 1'b1; b_wregno = 5'd9; b_regval = 32'h99;
    step();
    b_valid = 1'b0;
    q_regno = 5'd9; #1;
    n_checks++; if (q_pending !== 1'b1) begin n_fail++; $display("FAIL hz_hit: got %0b exp 1", q_pending); end
    q_regno = 5'd8; #1;
    n_checks++; if (q_pending !== 1'b0) begin n_fail++; $display("FAIL hz_miss: got %0b exp 0", q_pending); end
    a_valid = 1'b0;
    step();
    q_regno = 5'd9; #1;
    n_checks++; if (q_pending !== 1'b0) begin n_fail++; $display("FAIL hz_after_pop: got %0b exp 0", q_pending); end
    q_regno = 5'd0;
  endtask
`endif

  task automatic test_reset_mid();
    a_valid = 1'b1; a_wregno = 5'd6; a_regval = 32'h66;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_wregno = 5'(20 + i); b_regval = 32'hC0 + 32'(i);
      step();
    end
    b_valid = 1'b0;
    for (int c = 4; c <= 10; c++) step();
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL mid_stall_pre: got %0b exp 1", stall_out); end
    n_checks++; if (b_count !== 3'd3) begin n_fail++; $display("FAIL mid_count_pre: got %0d exp 3", b_count); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %0b exp 0", wr_en); end
    n_checks++; if (wr_regno !== 5'd0) begin n_fail++; $display("FAIL mid_wr_regno: got %0d exp 0", wr_regno); end
    n_checks++; if (wr_data !== 32'd0) begin n_fail++; $display("FAIL mid_wr_data: got %h exp 0", wr_data); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %0b exp 0", stall_out); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_proto: got %0b exp 0", proto_err); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d exp 0", b_count); end
`ifdef WB_ARB_HAZARD_EN
    for (int r = 0; r < 32; r++) begin
      q_regno = 5'(r); #0.1;
      n_checks++; if (q_pending !== 1'b0) begin n_fail++; $display("FAIL mid_q_pending_r%0d: got %0b exp 0", r, q_pending); end
    end
    q_regno = 5'd0;
`endif
    idle_inputs();
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL mid_b_ready: got %0b exp 1", b_ready); end
    step();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_post_wr_en: got %0b exp 0", wr_en); end
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL mid_post_count: got %0d exp 0", b_count); end
  endtask

  initial begin
    idle_inputs();
`ifdef WB_ARB_HAZARD_EN
    q_regno = 5'd0;
`endif
    test_reset();
    test_a_only();
    test_b_only();
    test_fill_starve();
    test_proto_x0();
`ifdef WB_ARB_HAZARD_EN
    test_hazard();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
